// File: rtl/deadlock_report_ctrl.sv
// Qualifies deadlock-monitor block over a confirmation window, then
// reports blocked AXIS channels one beat at a time and halts.
module deadlock_report_ctrl #(
  parameter int N_AXIS         = 15,
  parameter int N_INST         = 2,
  parameter int CONFIRM_CYCLES = 16,
  parameter int CHAN_W         = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              monitor_block,
  input  logic [N_AXIS-1:0] axis_block_sigs,
  input  logic [N_INST-1:0] inst_idle_sigs,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic [CHAN_W-1:0] rpt_chan,
  output logic              rpt_last,
  output logic [31:0]       rpt_cycle,
  output logic              deadlock
);

  typedef enum logic [2:0] {
    IDLE,
    WATCH,
    SUSPECT,
    REPORT,
    HALT
  } state_t;

  localparam logic [15:0] CONF = 16'(CONFIRM_CYCLES);

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d, cnt_inc;
  logic [N_AXIS-1:0] mask_q, mask_d;
  logic [31:0]       cyc_q, cyc_d, rcyc_d;
  logic              qual;

  // All-idle instances mean the design finished, not deadlocked.
  assign qual    = monitor_block & ~(&inst_idle_sigs);
  assign cnt_inc = cnt_q + 16'd1;

  function automatic logic [CHAN_W-1:0] low_idx(
    input logic [N_AXIS-1:0] m
  );
    logic [CHAN_W-1:0] r;
    r = CHAN_W'(N_AXIS);
    for (int i = N_AXIS - 1; i >= 0; i--)
      if (m[i]) r = CHAN_W'(i);
    return r;
  endfunction

  function automatic logic at_most_one(
    input logic [N_AXIS-1:0] m
  );
    return ~|(m & (m - N_AXIS'(1)));
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mask_d  = mask_q;
    cyc_d   = cyc_q;
    rcyc_d  = rpt_cycle;
    if (state_q != IDLE && cyc_q != 32'hFFFF_FFFF)
      cyc_d = cyc_q + 32'd1;
    unique case (state_q)
      IDLE: begin
        cnt_d   = '0;
        mask_d  = '0;
        cyc_d   = '0;
        rcyc_d  = '0;
        state_d = WATCH;
      end
      WATCH: begin
        if (qual) begin
          cnt_d   = 16'd1;
          mask_d  = axis_block_sigs;
          state_d = SUSPECT;
        end
      end
      SUSPECT: begin
        if (qual) begin
          cnt_d  = cnt_inc;
          mask_d = mask_q | axis_block_sigs;
          if (cnt_inc == CONF) begin
            state_d = REPORT;
            rcyc_d  = cyc_q;
          end
        end else begin
          cnt_d   = '0;
          mask_d  = '0;
          state_d = WATCH;
        end
      end
      REPORT: begin
        if (rpt_valid && rpt_ready) begin
          if (rpt_last) state_d = HALT;
          else mask_d = mask_q & (mask_q - N_AXIS'(1));
        end
      end
      HALT: ;
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d = IDLE;
      cnt_d   = '0;
      mask_d  = '0;
      cyc_d   = '0;
      rcyc_d  = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mask_q    <= '0;
      cyc_q     <= '0;
      rpt_valid <= 1'b0;
      rpt_chan  <= '0;
      rpt_last  <= 1'b0;
      rpt_cycle <= '0;
      deadlock  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      cyc_q     <= cyc_d;
      rpt_cycle <= rcyc_d;
      rpt_valid <= (state_d == REPORT);
      deadlock  <= (state_d == HALT);
      // Beat fields precomputed from the next mask keep outputs registered.
      if (state_d == REPORT) begin
        rpt_chan <= low_idx(mask_d);
        rpt_last <= at_most_one(mask_d);
      end else begin
        rpt_chan <= '0;
        rpt_last <= 1'b0;
      end
    end
  end

endmodule
